// File: rtl/aes_pkg.sv
// Shared AES definitions: state layout, controller state encoding, round
// constant arithmetic.
package aes_pkg;

  typedef logic [0:3][0:3][7:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  localparam int NR_AES128 = 10;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_rcon_gen.sv
// Round-constant register: init loads 01, advance steps it by xtime.
// Shared with key-expansion logic.
module rcon_gen
  import aes_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       init_i,
  input  logic       advance_i,
  output logic [7:0] rcon_o
);

  logic [7:0] rcon_q, rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (init_i) begin
      rcon_d = 8'h01;
    end else if (advance_i) begin
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rcon_q <= 8'h01;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: drives datapath load/round/skip-mix
// controls and the round constant, one round per clock.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR       = NR_AES128,
  parameter bit HOLD_OUT = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       dp_load_init_o,
  output logic       dp_round_en_o,
  output logic       dp_skip_mix_o,
  output logic [7:0] rcon_o,
  output logic [3:0] round_idx_o,
  output logic       busy_o
);

  ctrl_state_e state_q, state_d;
  logic [3:0]  round_idx_q, round_idx_d;
  logic        round_en_q, round_en_d;
  logic        skip_mix_q, skip_mix_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        rcon_init, rcon_adv;
  logic        accept;

  assign accept = (state_q == IDLE) && in_valid_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      round_idx_q <= 4'd0;
      round_en_q  <= 1'b0;
      skip_mix_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
      round_en_q  <= round_en_d;
      skip_mix_q  <= skip_mix_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    round_idx_d = round_idx_q;
    rcon_init   = 1'b0;
    rcon_adv    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ROUND;
          round_idx_d = 4'd1;
          rcon_init   = 1'b1;
        end
      end
      ROUND: begin
        round_idx_d = round_idx_q + 4'd1;
        rcon_adv    = 1'b1;
        if (round_idx_q == 4'(NR - 1)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        state_d = DONE;
      end
      DONE: begin
        if (!HOLD_OUT || out_ready_i) begin
          state_d     = IDLE;
          round_idx_d = 4'd0;
          rcon_init   = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        round_idx_d = 4'd0;
        rcon_init   = 1'b1;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    round_en_d  = (state_d == ROUND) || (state_d == FINAL);
    skip_mix_d  = (state_d == FINAL);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == ROUND) || (state_d == FINAL);
  end

  rcon_gen u_rcon_gen (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .init_i    (rcon_init),
    .advance_i (rcon_adv),
    .rcon_o    (rcon_o)
  );

  assign in_ready_o     = (state_q == IDLE);
  assign dp_load_init_o = accept;
  assign dp_round_en_o  = round_en_q;
  assign dp_skip_mix_o  = skip_mix_q;
  assign out_valid_o    = out_valid_q;
  assign round_idx_o    = round_idx_q;
  assign busy_o         = busy_q;

  a_no_load_and_round: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(dp_load_init_o && dp_round_en_o));

  a_round_idx_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    round_idx_o <= 4'(NR));

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural AES-128 round datapath
// attached to its controls.
module tb_aes_round_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       dp_load_init;
  logic       dp_round_en;
  logic       dp_skip_mix;
  logic [7:0] rcon;
  logic [3:0] round_idx;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  aes_round_ctrl #(.NR(10), .HOLD_OUT(1'b1)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .dp_load_init_o (dp_load_init),
    .dp_round_en_o  (dp_round_en),
    .dp_skip_mix_o  (dp_skip_mix),
    .rcon_o         (rcon),
    .round_idx_o    (round_idx),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: byte i of a 128-bit word sits at [127-8i -: 8],
  // column-major (row = i%4, column = i/4).
  logic [7:0]   sbox [256];
  logic [127:0] pt  = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] key = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] st, kr;
  logic [7:0]   rc_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] m2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = m2(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        r[127-8*(4*col+row) -: 8] = sbox[s[127-8*(4*((col+row)%4)+row) -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int col = 0; col < 4; col++) begin
      a0 = s[127-32*col -: 8];
      a1 = s[119-32*col -: 8];
      a2 = s[111-32*col -: 8];
      a3 = s[103-32*col -: 8];
      r[127-32*col -: 8] = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*col -: 8] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
      r[111-32*col -: 8] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
      r[103-32*col -: 8] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
    end
    return r;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]};
    t  = t ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always @(posedge clk) begin
    if (dp_load_init) begin
      st <= pt ^ key;
      kr <= key;
    end else if (dp_round_en) begin
      st <= (dp_skip_mix ? sub_shift(st) : mix(sub_shift(st))) ^ kexp(kr, rcon);
      kr <= kexp(kr, rcon);
    end
  end

  task automatic chk(input string tag, input bit ok, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] inv, s;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
          ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
      sbox[a] = s;
    end

    next_cyc();
    next_cyc();
    #1;
    chk("rst_in_ready", in_ready === 1'b1, in_ready, 1'b1);
    chk("rst_out_valid", out_valid === 1'b0, out_valid, 1'b0);
    chk("rst_load_init", dp_load_init === 1'b0, dp_load_init, 1'b0);
    chk("rst_round_en", dp_round_en === 1'b0, dp_round_en, 1'b0);
    chk("rst_skip_mix", dp_skip_mix === 1'b0, dp_skip_mix, 1'b0);
    chk("rst_rcon", rcon === 8'h01, rcon, 8'h01);
    chk("rst_round_idx", round_idx === 4'd0, round_idx, 4'd0);
    chk("rst_busy", busy === 1'b0, busy, 1'b0);
    rst_n = 1'b1;

    // Single block; accept cycle is cycle 0.
    next_cyc();
    in_valid = 1'b1;
    #1;
    chk("c0_load_init", dp_load_init === 1'b1, dp_load_init, 1'b1);
    chk("c0_in_ready", in_ready === 1'b1, in_ready, 1'b1);
    chk("c0_round_en", dp_round_en === 1'b0, dp_round_en, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      next_cyc();
      in_valid = 1'b0;
      #1;
      chk("rnd_round_en", dp_round_en === 1'b1, dp_round_en, 1'b1);
      chk("rnd_skip_mix", dp_skip_mix === (c == 10), dp_skip_mix, (c == 10));
      chk("rnd_round_idx", round_idx === 4'(c), round_idx, 4'(c));
      chk("rnd_rcon", rcon === rc_exp[c-1], rcon, rc_exp[c-1]);
      chk("rnd_load_init", dp_load_init === 1'b0, dp_load_init, 1'b0);
      chk("rnd_in_ready", in_ready === 1'b0, in_ready, 1'b0);
      chk("rnd_busy", busy === 1'b1, busy, 1'b1);
      chk("rnd_out_valid", out_valid === 1'b0, out_valid, 1'b0);
    end
    next_cyc();
    #1;
    chk("c11_out_valid", out_valid === 1'b1, out_valid, 1'b1);
    chk("c11_round_en", dp_round_en === 1'b0, dp_round_en, 1'b0);
    chk("c11_busy", busy === 1'b0, busy, 1'b0);
    chk("c11_in_ready", in_ready === 1'b0, in_ready, 1'b0);
    chk("c11_ciphertext", st === 128'h69c4e0d86a7b0430d8cdb78070b4c55a, st,
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Back-pressure: out_ready low for cycles 11..15; in_valid ignored meanwhile.
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      in_valid = 1'b1;
      #1;
      chk("bp_out_valid", out_valid === 1'b1, out_valid, 1'b1);
      chk("bp_in_ready", in_ready === 1'b0, in_ready, 1'b0);
      chk("bp_load_init", dp_load_init === 1'b0, dp_load_init, 1'b0);
    end
    next_cyc();
    out_ready = 1'b1;
    #1;
    chk("rel_out_valid", out_valid === 1'b1, out_valid, 1'b1);
    chk("rel_in_ready", in_ready === 1'b0, in_ready, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    for (int c = 0; c <= 36; c++) begin
      next_cyc();
      #1;
      chk("b2b_load_init", dp_load_init === (c % 12 == 0), dp_load_init, (c % 12 == 0));
      chk("b2b_in_ready", in_ready === (c % 12 == 0), in_ready, (c % 12 == 0));
      chk("b2b_out_valid", out_valid === (c % 12 == 11), out_valid, (c % 12 == 11));
      chk("b2b_round_en", dp_round_en === (c % 12 >= 1 && c % 12 <= 10), dp_round_en,
          (c % 12 >= 1 && c % 12 <= 10));
    end

    // Asynchronous reset during round 5 of the last accepted block.
    for (int k = 1; k <= 5; k++) begin
      next_cyc();
      in_valid = 1'b0;
      #1;
    end
    chk("ar_round_idx_pre", round_idx === 4'd5, round_idx, 4'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_round_en", dp_round_en === 1'b0, dp_round_en, 1'b0);
    chk("ar_round_idx", round_idx === 4'd0, round_idx, 4'd0);
    chk("ar_rcon", rcon === 8'h01, rcon, 8'h01);
    chk("ar_busy", busy === 1'b0, busy, 1'b0);
    chk("ar_in_ready", in_ready === 1'b1, in_ready, 1'b1);
    chk("ar_out_valid", out_valid === 1'b0, out_valid, 1'b0);
    chk("ar_skip_mix", dp_skip_mix === 1'b0, dp_skip_mix, 1'b0);
    next_cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      next_cyc();
      #1;
      chk("post_rst_out_valid", out_valid === 1'b0, out_valid, 1'b0);
      chk("post_rst_busy", busy === 1'b0, busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
